// File: rtl/svnet_fifo_packer_pkg.sv
// svnet_fifo_packer_pkg: shared state encoding and FIFO count-width helper for the packer
package svnet_fifo_packer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} packer_state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/svnet_fifo_packer.sv
// svnet_fifo_packer: drains narrow words from an upstream FIFO and packs RATIO of them into wide downstream writes
module svnet_fifo_packer
  import svnet_fifo_packer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int LEN_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cmd_valid,
  input  logic [LEN_W-1:0]              i_cmd_len,
  output logic                          o_cmd_ready,
  input  logic [cnt_w(IN_DEPTH)-1:0]    i_in_used_space,
  input  logic [WIDTH-1:0]              i_in_read_data,
  output logic                          o_in_read,
  input  logic [cnt_w(OUT_DEPTH)-1:0]   i_out_free_space,
  output logic                          o_out_write,
  output logic [WIDTH*RATIO-1:0]        o_out_write_data,
  output logic                          o_busy,
  output logic                          o_done
);
  localparam int LW = $clog2(RATIO) + 1;
  localparam int SW = $clog2(RATIO);
  packer_state_t                    r_state, w_state_nxt;
  logic [LEN_W-1:0]                 r_rem;
  logic [LW-1:0]                    r_lane, w_lane_inc;
  logic [RATIO-1:0][WIDTH-1:0]      r_buf, w_buf_nxt;
  logic                             r_full, w_rd, w_wr, w_fill;
  // reset gates the handshakes so an aborted burst pops nothing more from upstream
  assign w_wr       = !rst && r_full && i_out_free_space != '0;
  assign w_rd       = !rst && r_state == RUN && r_rem != '0 && i_in_used_space != '0 && (!r_full || w_wr);
  assign w_lane_inc = r_lane + 1'b1;
  assign w_fill     = w_rd && (w_lane_inc == LW'(RATIO) || r_rem == LEN_W'(1));
  always_comb begin
    w_state_nxt = r_state == IDLE ? (i_cmd_valid ? (i_cmd_len == '0 ? DONE : RUN) : IDLE)
                : r_state == RUN  ? (w_wr && r_rem == '0 ? DONE : RUN)
                : IDLE;
    w_buf_nxt = w_wr ? '0 : r_buf;
    if (w_rd) w_buf_nxt[r_lane[SW-1:0]] = i_in_read_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_lane  <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= r_state == IDLE && i_cmd_valid ? i_cmd_len : w_rd ? r_rem - 1'b1 : r_rem;
      r_lane  <= w_fill ? '0 : w_rd ? w_lane_inc : r_lane;
      r_buf   <= w_buf_nxt;
      r_full  <= w_fill ? 1'b1 : w_wr ? 1'b0 : r_full;
      assert (!(w_rd && i_in_used_space == '0));
      assert (!(w_wr && i_out_free_space == '0));
    end
  end
  assign o_cmd_ready      = r_state == IDLE;
  assign o_busy           = r_state != IDLE;
  assign o_done           = r_state == DONE;
  assign o_in_read        = w_rd;
  assign o_out_write      = w_wr;
  assign o_out_write_data = r_buf;
endmodule

// File: tb/tb_svnet_fifo_packer.sv
// tb_svnet_fifo_packer: directed bursts against a queue-modelled upstream FIFO and a packed-word scoreboard
module tb_svnet_fifo_packer;
  localparam int W = 8, R = 4, D = 4, LW = 16;
  logic            clk = 1'b0, rst = 1'b1;
  logic            i_cmd_valid = 1'b0;
  logic [LW-1:0]   i_cmd_len = '0;
  logic            o_cmd_ready;
  logic [2:0]      i_in_used_space = '0;
  logic [W-1:0]    i_in_read_data = '0;
  logic            o_in_read;
  logic [2:0]      i_out_free_space = 3'(D);
  logic            o_out_write;
  logic [W*R-1:0]  o_out_write_data;
  logic            o_busy, o_done;
  always #5 clk = ~clk;
  svnet_fifo_packer dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd_len(i_cmd_len), .o_cmd_ready(o_cmd_ready),
    .i_in_used_space(i_in_used_space), .i_in_read_data(i_in_read_data), .o_in_read(o_in_read),
    .i_out_free_space(i_out_free_space), .o_out_write(o_out_write), .o_out_write_data(o_out_write_data),
    .o_busy(o_busy), .o_done(o_done)
  );
  logic [W-1:0]   up_q[$];
  logic [W*R-1:0] exp_q[$];
  int vectors = 0, errs = 0, cyc_n = 0;
  int n_rd, n_wr, n_done, t_wr, t_done, rdy_lo;
  bit gate_alt = 0, gate = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // drive the upstream model, sample combinational handshakes mid-cycle, then step one clock
  task automatic cyc();
    int used;
    used = up_q.size() > D ? D : up_q.size();
    if (gate_alt) begin
      gate = !gate;
      if (gate) used = 0;
    end
    i_in_used_space = 3'(used);
    i_in_read_data  = up_q.size() != 0 ? up_q[0] : '0;
    #2;
    if (o_in_read) begin
      n_rd++;
      chk("rd_when_empty", 64'(used == 0), 64'd0);
      if (up_q.size() != 0) void'(up_q.pop_front());
    end
    if (o_out_write) begin
      n_wr++;
      t_wr = cyc_n;
      if (exp_q.size() != 0) chk("wdata", 64'(o_out_write_data), 64'(exp_q.pop_front()));
      else chk("spurious_wr", 64'(o_out_write), 64'd0);
    end
    if (!o_cmd_ready) rdy_lo++;
    if (o_done) begin
      n_done++;
      t_done = cyc_n;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  task automatic run_burst(input string tag, input int len, input int stall, input bit alt);
    int nw;
    logic [W*R-1:0] w;
    for (int i = 0; i < len; i++) up_q.push_back(8'(i + 1));
    nw = (len + R - 1) / R;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int j = 0; j < R; j++) if (i * R + j < len) w[j*W +: W] = 8'(i * R + j + 1);
      exp_q.push_back(w);
    end
    n_rd = 0; n_wr = 0; n_done = 0; rdy_lo = 0; t_wr = -1; t_done = -1;
    gate_alt = alt; gate = 0;
    i_out_free_space = stall > 0 ? 3'd0 : 3'(D);
    i_cmd_valid = 1'b1;
    i_cmd_len   = 16'(len);
    chk({tag, "_ready"}, 64'(o_cmd_ready), 64'd1);
    cyc();
    i_cmd_valid = 1'b0;
    for (int k = 0; k < stall; k++) cyc();
    if (stall > 0) begin
      chk({tag, "_stall_rd"}, 64'(n_rd), 64'(R));
      chk({tag, "_stall_wr"}, 64'(n_wr), 64'd0);
      i_out_free_space = 3'(D);
    end
    for (int k = 0; k < 200 && n_done == 0; k++) cyc();
    cyc();
    cyc();
    chk({tag, "_done_cnt"}, 64'(n_done), 64'd1);
    chk({tag, "_wr_cnt"}, 64'(n_wr), 64'(nw));
    chk({tag, "_rd_cnt"}, 64'(n_rd), 64'(len));
    chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    if (nw > 0) chk({tag, "_done_lat"}, 64'(t_done - t_wr), 64'd1);
    else chk({tag, "_ready_low"}, 64'(rdy_lo), 64'd1);
    chk({tag, "_idle_ready"}, 64'(o_cmd_ready), 64'd1);
    chk({tag, "_idle_busy"}, 64'(o_busy), 64'd0);
    gate_alt = 0;
  endtask
  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_rd", 64'(o_in_read), 64'd0);
    chk("rst_wr", 64'(o_out_write), 64'd0);
    chk("rst_data", 64'(o_out_write_data), 64'd0);
    run_burst("len8", 8, 0, 0);
    run_burst("len5", 5, 0, 0);
    run_burst("stall", 8, 10, 0);
    run_burst("len0", 0, 0, 0);
    run_burst("alt", 4, 0, 1);
    for (int i = 0; i < 4; i++) up_q.push_back(8'(8'h11 + i));
    n_rd = 0; n_wr = 0; n_done = 0;
    i_cmd_valid = 1'b1;
    i_cmd_len   = 16'd4;
    cyc();
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 20 && n_rd < 2; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_rd", 64'(n_rd), 64'd2);
    chk("mid_rst_ready", 64'(o_cmd_ready), 64'd1);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_done_now", 64'(o_done), 64'd0);
    cyc();
    cyc();
    cyc();
    chk("mid_rst_wr", 64'(n_wr), 64'd0);
    chk("mid_rst_done", 64'(n_done), 64'd0);
    chk("mid_rst_left", 64'(up_q.size()), 64'd2);
    up_q.delete();
    chk("end_busy", 64'(o_busy), 64'd0);
    chk("end_wr", 64'(o_out_write), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
